// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell is reused across
// WIDTH clock cycles to add two operands LSB first, with a start/busy/done handshake.

module HalfAdder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;

endmodule

// One-bit full adder built from two half adders and an OR for the carry.
module FullAdderCell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic halfSum;
  logic halfCarry0;
  logic halfCarry1;

  HalfAdder uHa0 (
    .x_i (a_i),
    .y_i (b_i),
    .s_o (halfSum),
    .c_o (halfCarry0)
  );

  HalfAdder uHa1 (
    .x_i (halfSum),
    .y_i (c_i),
    .s_o (s_o),
    .c_o (halfCarry1)
  );

  assign c_o = halfCarry0 | halfCarry1;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  // Only WIDTH-1 partial bits need storing; the last bit goes straight into sum.
  logic [WIDTH-2:0] sSh_q, sSh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bitSum;
  logic             bitCarry;
  logic [WIDTH-1:0] sShNext;
  logic             lastBit;

  FullAdderCell uCell (
    .a_i (aSh_q[0]),
    .b_i (bSh_q[0]),
    .c_i (carry_q),
    .s_o (bitSum),
    .c_o (bitCarry)
  );

  assign sShNext = {bitSum, sSh_q};
  assign lastBit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sSh_d   = sSh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        sSh_d   = sShNext[WIDTH-1:1];
        carry_d = bitCarry;
        cnt_d   = cnt_q + CW'(1);
        // sum/cout only move on the final bit so partial results never leak out.
        if (lastBit) begin
          sum_d   = sShNext;
          cout_d  = bitCarry;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sSh_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sSh_q   <= sSh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the handshake
// scenarios and a 2-bit instance swept over every operand combination.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] aVal, input logic [7:0] bVal, input logic cVal);
    @(negedge clk);
    start8 = 1'b1;
    a8     = aVal;
    b8     = bVal;
    cin8   = cVal;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Observes a job until its done pulse (bounded), recording what it saw.
  task automatic runJob8(input logic [7:0] aVal, input logic [7:0] bVal, input logic cVal,
                         output logic [7:0] sumObs, output logic coutObs,
                         output int busyCnt, output logic gotDone, output logic sumMoved);
    logic [7:0] sumBefore;
    sumBefore = sum8;
    busyCnt   = 0;
    gotDone   = 1'b0;
    sumMoved  = 1'b0;
    applyStimulus(aVal, bVal, cVal);
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        gotDone = 1'b1;
        break;
      end
      if (busy8) busyCnt++;
      if (sum8 !== sumBefore) sumMoved = 1'b1;
      @(negedge clk);
    end
    sumObs  = sum8;
    coutObs = cout8;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start8 = 1'b1;
    a8     = 8'hAA;
    b8     = 8'h00;
    cin8   = 1'b0;
    start2 = 1'b1;
    a2     = 2'd0;
    b2     = 2'd0;
    cin2   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy8); end
    total++;
    if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done8); end
    total++;
    if (sum8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_sum got=%h want=00", sum8); end
    total++;
    if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b want=0", cout8); end
    total++;
    if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy2 got=%b want=0", busy2); end
    start8 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_nojob got=%b want=0", busy8); end
  endtask

  task automatic test_basic_add;
    logic [7:0] s;
    logic       c;
    int         bc;
    logic       gd;
    logic       mv;
    runJob8(8'h35, 8'h4A, 1'b0, s, c, bc, gd, mv);
    total++;
    if (gd !== 1'b1) begin bad++; $display("[TB] FAIL basic_done got=%b want=1", gd); end
    total++;
    if (bc != 8) begin bad++; $display("[TB] FAIL basic_busy_cycles got=%0d want=8", bc); end
    total++;
    if (mv !== 1'b0) begin bad++; $display("[TB] FAIL basic_sum_stable got=%b want=0", mv); end
    total++;
    if (s !== 8'h7F) begin bad++; $display("[TB] FAIL basic_sum got=%h want=7f", s); end
    total++;
    if (c !== 1'b0) begin bad++; $display("[TB] FAIL basic_cout got=%b want=0", c); end
    @(negedge clk);
    total++;
    if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_width got=%b want=0", done8); end
  endtask

  task automatic test_wrap;
    logic [7:0] s;
    logic       c;
    int         bc;
    logic       gd;
    logic       mv;
    runJob8(8'hFF, 8'h01, 1'b0, s, c, bc, gd, mv);
    total++;
    if (gd !== 1'b1 || s !== 8'h00) begin bad++; $display("[TB] FAIL wrap_sum got=%h done=%b want=00", s, gd); end
    total++;
    if (c !== 1'b1) begin bad++; $display("[TB] FAIL wrap_cout got=%b want=1", c); end
    runJob8(8'hFF, 8'hFF, 1'b1, s, c, bc, gd, mv);
    total++;
    if (gd !== 1'b1 || s !== 8'hFF) begin bad++; $display("[TB] FAIL max_sum got=%h done=%b want=ff", s, gd); end
    total++;
    if (c !== 1'b1) begin bad++; $display("[TB] FAIL max_cout got=%b want=1", c); end
  endtask

  task automatic test_ignore_start;
    int   doneCnt;
    logic gotDone;
    applyStimulus(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'hF0;
    b8     = 8'h0F;
    @(negedge clk);
    start8 = 1'b0;
    gotDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        gotDone = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (gotDone !== 1'b1 || sum8 !== 8'h30) begin bad++; $display("[TB] FAIL ignore_sum got=%h done=%b want=30", sum8, gotDone); end
    total++;
    if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_cout got=%b want=0", cout8); end
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) doneCnt++;
    end
    total++;
    if (doneCnt != 0) begin bad++; $display("[TB] FAIL ignore_extra_done got=%0d want=0", doneCnt); end
  endtask

  task automatic test_reset_midrun;
    int         doneCnt;
    logic [7:0] s;
    logic       c;
    int         bc;
    logic       gd;
    logic       mv;
    applyStimulus(8'h81, 8'h81, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) doneCnt++;
      @(negedge clk);
    end
    total++;
    if (doneCnt != 0) begin bad++; $display("[TB] FAIL abort_done got=%0d want=0", doneCnt); end
    total++;
    if (sum8 !== 8'h00) begin bad++; $display("[TB] FAIL abort_sum got=%h want=00", sum8); end
    total++;
    if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL abort_cout got=%b want=0", cout8); end
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy8); end
    runJob8(8'h81, 8'h81, 1'b0, s, c, bc, gd, mv);
    total++;
    if (gd !== 1'b1 || s !== 8'h02) begin bad++; $display("[TB] FAIL rerun_sum got=%h done=%b want=02", s, gd); end
    total++;
    if (c !== 1'b1) begin bad++; $display("[TB] FAIL rerun_cout got=%b want=1", c); end
  endtask

  // WIDTH=2 sweep: combo index k encodes a=k[4:3], b=k[2:1], cin=k[0].
  task automatic test_exhaustive_w2;
    int         accepted;
    int         doneCnt;
    int         lastDone;
    logic       prevBusy;
    logic [4:0] k;
    logic [2:0] expect3;
    k        = 5'd0;
    a2       = k[4:3];
    b2       = k[2:1];
    cin2     = k[0];
    accepted = 0;
    doneCnt  = 0;
    lastDone = 0;
    prevBusy = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (busy2 && !prevBusy) begin
        accepted++;
        k    = 5'(accepted);
        a2   = k[4:3];
        b2   = k[2:1];
        cin2 = k[0];
      end
      prevBusy = busy2;
      if (done2) begin
        k       = 5'(doneCnt);
        expect3 = {1'b0, k[4:3]} + {1'b0, k[2:1]} + {2'b00, k[0]};
        total++;
        if ({cout2, sum2} !== expect3) begin
          bad++;
          $display("[TB] FAIL w2_sum combo=%0d got=%b want=%b", doneCnt, {cout2, sum2}, expect3);
        end
        if (doneCnt > 0) begin
          total++;
          if (cyc - lastDone != 4) begin
            bad++;
            $display("[TB] FAIL w2_spacing combo=%0d got=%0d want=4", doneCnt, cyc - lastDone);
          end
        end
        lastDone = cyc;
        doneCnt++;
        if (doneCnt == 32) begin
          start2 = 1'b0;
          break;
        end
      end
    end
    start2 = 1'b0;
    total++;
    if (doneCnt != 32) begin bad++; $display("[TB] FAIL w2_job_count got=%0d want=32", doneCnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_add();
    test_wrap();
    test_ignore_start();
    test_reset_midrun();
    test_exhaustive_w2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
